// File: rtl/dram_pkg.sv
// Shared DRAM controller definitions: command encodings driven on the
// cmd bus and the state encoding of the refresh engine FSM.
package dram_pkg;

    localparam logic [1:0] CMD_NOP     = 2'b00;
    localparam logic [1:0] CMD_READ    = 2'b01;
    localparam logic [1:0] CMD_WRITE   = 2'b10;
    localparam logic [1:0] CMD_REFRESH = 2'b11;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_GNT = 3'd1,
        REQ      = 3'd2,
        REL      = 3'd3,
        NEXT     = 3'd4
    } ref_state_e;

endpackage

// File: rtl/dram_refresh_timer.sv
// Refresh interval timer: free-running down-counter that emits a one-cycle
// expire pulse while it sits at zero, then reloads REFRESH_INTERVAL-1.
module dram_refresh_timer #(
    parameter int REFRESH_INTERVAL = 1024
) (
    input  logic clk,
    input  logic rst_b,
    output logic expire
);

    localparam int CNT_W = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(REFRESH_INTERVAL - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Terminal-count compare and reload / decrement selection
    always_comb begin
        expire = (cnt_q == '0);
        cnt_d  = expire ? RELOAD : cnt_q - CNT_W'(1);
    end

    // Counter register, starts a full interval out of reset
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) cnt_q <= RELOAD;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/dram_refresh_ctrl.sv
// Periodic DRAM refresh engine. Tracks postponed refresh events, requests
// the bus from the access FSM and, once granted, issues one REFRESH per bank
// for the current row over the cmd_req/cmd_ack four-phase handshake.
// Optional build macro DRAM_REFRESH_STATS_EN enables the refresh_cnt
// completed-row counter; without it refresh_cnt reads as 0.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   IDLE     | no refresh pending
//   WAIT_GNT | refresh pending, waiting for access FSM grant
//   REQ      | cmd_req high with CMD_REFRESH, waiting for ack
//   REL      | cmd_req low, waiting for ack to drop
//   NEXT     | advance bank, or finish the row
module dram_refresh_ctrl
    import dram_pkg::*;
#(
    parameter int NUM_OF_BANKS     = 8,
    parameter int NUM_OF_ROWS      = 128,
    parameter int REFRESH_INTERVAL = 1024,
    parameter int MAX_POSTPONE     = 4,
    localparam int BANK_W = $clog2(NUM_OF_BANKS),
    localparam int ROW_W  = $clog2(NUM_OF_ROWS)
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              ref_gnt,
    input  logic              cmd_ack,
    output logic              cmd_req,
    output logic [1:0]        cmd,
    output logic [BANK_W-1:0] ref_bank_id,
    output logic [ROW_W-1:0]  ref_row_id,
    output logic              refresh_flag,
    output logic              refresh_urgent,
    output logic              refresh_busy,
    output logic              refresh_overrun,
    output logic [15:0]       refresh_cnt
);

    localparam int PEND_W = $clog2(MAX_POSTPONE + 1);
    localparam logic [PEND_W-1:0] PEND_MAX  = PEND_W'(MAX_POSTPONE);
    localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_OF_BANKS - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(NUM_OF_ROWS - 1);

    ref_state_e        state_q, state_d;
    logic [PEND_W-1:0] pending_q, pending_d;
    logic [BANK_W-1:0] bank_q, bank_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic              flag_q, urgent_q, busy_q, overrun_q, overrun_d;
    logic              expire, row_done;

    dram_refresh_timer #(
        .REFRESH_INTERVAL(REFRESH_INTERVAL)
    ) u_timer (
        .clk    (clk),
        .rst_b  (rst_b),
        .expire (expire)
    );

    // Pending-event bookkeeping; a simultaneous expire and row_done cancel out
    always_comb begin
        pending_d = pending_q;
        overrun_d = overrun_q;
        if (expire && !row_done) begin
            if (pending_q == PEND_MAX) overrun_d = 1'b1;
            else                       pending_d = pending_q + PEND_W'(1);
        end else if (!expire && row_done) begin
            pending_d = pending_q - PEND_W'(1);
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state logic; end of row looks at the post-update pending count
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (flag_q)   state_d = WAIT_GNT;
            WAIT_GNT: if (ref_gnt)  state_d = REQ;
            REQ:      if (cmd_ack)  state_d = REL;
            REL:      if (!cmd_ack) state_d = NEXT;
            NEXT: begin
                if (bank_q != LAST_BANK)   state_d = REQ;
                else if (pending_d != '0)  state_d = WAIT_GNT;
                else                       state_d = IDLE;
            end
            default:                  state_d = IDLE;
        endcase
    end

    // FSM outputs: handshake request, command code and end-of-row strobe
    always_comb begin
        cmd_req  = (state_q == REQ);
        cmd      = cmd_req ? CMD_REFRESH : CMD_NOP;
        row_done = (state_q == NEXT) && (bank_q == LAST_BANK);
    end

    // Bank / row address advance
    always_comb begin
        bank_d = bank_q;
        row_d  = row_q;
        if (state_q == NEXT) begin
            if (bank_q != LAST_BANK) begin
                bank_d = bank_q + BANK_W'(1);
            end else begin
                bank_d = '0;
                row_d  = (row_q == LAST_ROW) ? '0 : row_q + ROW_W'(1);
            end
        end
    end

    // Datapath and registered status flags
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            pending_q <= '0;
            overrun_q <= 1'b0;
            bank_q    <= '0;
            row_q     <= '0;
            flag_q    <= 1'b0;
            urgent_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            bank_q    <= bank_d;
            row_q     <= row_d;
            flag_q    <= (pending_d != '0);
            urgent_q  <= (pending_d == PEND_MAX);
            busy_q    <= (state_d != IDLE);
        end
    end

`ifdef DRAM_REFRESH_STATS_EN
    logic [15:0] stat_cnt_q;

    // Completed-row counter, saturating
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b)                                stat_cnt_q <= 16'd0;
        else if (row_done && stat_cnt_q != 16'hFFFF) stat_cnt_q <= stat_cnt_q + 16'd1;
    end

    assign refresh_cnt = stat_cnt_q;
`else
    assign refresh_cnt = 16'd0;
`endif

    assign ref_bank_id     = bank_q;
    assign ref_row_id      = row_q;
    assign refresh_flag    = flag_q;
    assign refresh_urgent  = urgent_q;
    assign refresh_busy    = busy_q;
    assign refresh_overrun = overrun_q;

endmodule

// File: tb/tb_dram_refresh_ctrl.sv
// Directed bench for dram_refresh_ctrl with REFRESH_INTERVAL=64.
// Edge numbers in comments count rising edges after reset release.
module tb_dram_refresh_ctrl;

`ifdef DRAM_REFRESH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk, rst_b, ref_gnt, cmd_ack;
    logic        cmd_req;
    logic [1:0]  cmd;
    logic [2:0]  ref_bank_id;
    logic [6:0]  ref_row_id;
    logic        refresh_flag, refresh_urgent, refresh_busy, refresh_overrun;
    logic [15:0] refresh_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // {cmd, row, bank} captured at each rising edge of cmd_req
    logic [11:0] req_log[$];
    logic        req_prev = 1'b0;

    dram_refresh_ctrl #(
        .NUM_OF_BANKS     (8),
        .NUM_OF_ROWS      (128),
        .REFRESH_INTERVAL (64),
        .MAX_POSTPONE     (4)
    ) dut (
        .clk             (clk),
        .rst_b           (rst_b),
        .ref_gnt         (ref_gnt),
        .cmd_ack         (cmd_ack),
        .cmd_req         (cmd_req),
        .cmd             (cmd),
        .ref_bank_id     (ref_bank_id),
        .ref_row_id      (ref_row_id),
        .refresh_flag    (refresh_flag),
        .refresh_urgent  (refresh_urgent),
        .refresh_busy    (refresh_busy),
        .refresh_overrun (refresh_overrun),
        .refresh_cnt     (refresh_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // DRAM model: ack mirrors req half a cycle later
    initial begin
        cmd_ack = 1'b0;
        forever begin
            @(negedge clk);
            cmd_ack = cmd_req;
        end
    end

    // Request monitor
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (cmd_req && !req_prev) req_log.push_back({cmd, ref_row_id, ref_bank_id});
            req_prev = cmd_req;
        end
    end

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_b = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_b = 1'b1;
    endtask

    task automatic test_reset();
        ref_gnt = 1'b1;
        rst_b   = 1'b0;
        wait_edges(4);
        n_checks++;
        if ({cmd_req, cmd, ref_bank_id, ref_row_id} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_bus: got req=%0d cmd=%0d bank=%0d row=%0d expected all 0",
                     cmd_req, cmd, ref_bank_id, ref_row_id);
        end
        n_checks++;
        if ({refresh_flag, refresh_urgent, refresh_busy, refresh_overrun} !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 0000",
                     {refresh_flag, refresh_urgent, refresh_busy, refresh_overrun});
        end
        n_checks++;
        if (refresh_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %0d expected 0", refresh_cnt);
        end
    endtask

    task automatic test_first_row();
        int i;
        ref_gnt = 1'b1;
        do_reset();
        req_log.delete();
        wait_edges(63);
        n_checks++;
        if (refresh_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL first_flag_early: got %0d expected 0 after edge 63", refresh_flag);
        end
        wait_edges(1);
        n_checks++;
        if (refresh_flag !== 1'b1) begin
            n_fail++;
            $display("FAIL first_flag_rise: got %0d expected 1 after edge 64", refresh_flag);
        end
        i = 0;
        do begin wait_edges(1); i++; end while (refresh_flag && i < 200);
        n_checks++;
        if (i != 26) begin
            n_fail++;
            $display("FAIL first_row_time: flag dropped after %0d edges expected 26", i);
        end
        n_checks++;
        if (req_log.size() != 8) begin
            n_fail++;
            $display("FAIL first_row_reqs: got %0d requests expected 8", req_log.size());
        end
        for (int k = 0; k < 8 && k < req_log.size(); k++) begin
            n_checks++;
            if (req_log[k] !== {2'b11, 7'd0, 3'(k)}) begin
                n_fail++;
                $display("FAIL first_row_req%0d: got cmd=%0d row=%0d bank=%0d expected cmd=3 row=0 bank=%0d",
                         k, req_log[k][11:10], req_log[k][9:3], req_log[k][2:0], k);
            end
        end
        n_checks++;
        if ({ref_row_id, ref_bank_id, refresh_busy, cmd} !== {7'd1, 3'd0, 1'b0, 2'b00}) begin
            n_fail++;
            $display("FAIL first_row_end: got row=%0d bank=%0d busy=%0d cmd=%0d expected row=1 bank=0 busy=0 cmd=0",
                     ref_row_id, ref_bank_id, refresh_busy, cmd);
        end
        n_checks++;
        if (refresh_cnt !== (STATS ? 16'd1 : 16'd0)) begin
            n_fail++;
            $display("FAIL first_row_cnt: got %0d expected %0d", refresh_cnt, STATS ? 1 : 0);
        end
    endtask

    task automatic test_saturate();
        int i;
        ref_gnt = 1'b0;
        do_reset();
        wait_edges(322);
        n_checks++;
        if ({refresh_flag, refresh_urgent, refresh_overrun, refresh_busy, cmd_req} !== 5'b11110) begin
            n_fail++;
            $display("FAIL sat_flags: got flag/urg/ovr/busy/req=%b expected 11110",
                     {refresh_flag, refresh_urgent, refresh_overrun, refresh_busy, cmd_req});
        end
        req_log.delete();
        ref_gnt = 1'b1;
        // 4 saved events plus the expiry at edge 384 -> 5 rows, last done at edge 447
        i = 0;
        do begin wait_edges(1); i++; end while (refresh_flag && i < 300);
        n_checks++;
        if (i != 125) begin
            n_fail++;
            $display("FAIL sat_drain_time: flag dropped after %0d edges expected 125", i);
        end
        n_checks++;
        if (req_log.size() != 40) begin
            n_fail++;
            $display("FAIL sat_reqs: got %0d requests expected 40", req_log.size());
        end
        for (int k = 0; k < 40 && k < req_log.size(); k++) begin
            n_checks++;
            if (req_log[k] !== {2'b11, 7'(k / 8), 3'(k % 8)}) begin
                n_fail++;
                $display("FAIL sat_req%0d: got row=%0d bank=%0d expected row=%0d bank=%0d",
                         k, req_log[k][9:3], req_log[k][2:0], k / 8, k % 8);
            end
        end
        n_checks++;
        if ({refresh_overrun, refresh_urgent, refresh_busy} !== 3'b100) begin
            n_fail++;
            $display("FAIL sat_end: got ovr/urg/busy=%b expected 100",
                     {refresh_overrun, refresh_urgent, refresh_busy});
        end
        n_checks++;
        if (refresh_cnt !== (STATS ? 16'd5 : 16'd0)) begin
            n_fail++;
            $display("FAIL sat_cnt: got %0d expected %0d", refresh_cnt, STATS ? 5 : 0);
        end
    endtask

    task automatic test_coincide();
        ref_gnt = 1'b0;
        do_reset();
        wait_edges(103);
        ref_gnt = 1'b1;
        // REQ at edge 104, row_done lands on edge 128 together with the 2nd expiry
        wait_edges(25);
        n_checks++;
        if ({refresh_flag, refresh_busy, refresh_urgent, refresh_overrun} !== 4'b1100) begin
            n_fail++;
            $display("FAIL coincide_flags: got flag/busy/urg/ovr=%b expected 1100",
                     {refresh_flag, refresh_busy, refresh_urgent, refresh_overrun});
        end
        n_checks++;
        if ({ref_row_id, ref_bank_id} !== {7'd1, 3'd0}) begin
            n_fail++;
            $display("FAIL coincide_addr: got row=%0d bank=%0d expected row=1 bank=0",
                     ref_row_id, ref_bank_id);
        end
        wait_edges(1);
        n_checks++;
        if ({cmd_req, cmd} !== 3'b111) begin
            n_fail++;
            $display("FAIL coincide_req: got req=%0d cmd=%0d expected req=1 cmd=3", cmd_req, cmd);
        end
    endtask

    task automatic test_reset_mid_req();
        int i;
        ref_gnt = 1'b1;
        do_reset();
        i = 0;
        do begin wait_edges(1); i++; end while (!cmd_req && i < 200);
        n_checks++;
        if (i != 66) begin
            n_fail++;
            $display("FAIL midreq_first_req: cmd_req rose after %0d edges expected 66", i);
        end
        rst_b = 1'b0;
        #1;
        n_checks++;
        if ({cmd_req, cmd, ref_bank_id, ref_row_id, refresh_flag, refresh_busy} !== 15'd0) begin
            n_fail++;
            $display("FAIL midreq_async: got req=%0d cmd=%0d bank=%0d row=%0d flag=%0d busy=%0d expected all 0",
                     cmd_req, cmd, ref_bank_id, ref_row_id, refresh_flag, refresh_busy);
        end
        @(negedge clk);
        rst_b = 1'b1;
        wait_edges(63);
        n_checks++;
        if (refresh_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL midreq_flag_early: got %0d expected 0 after edge 63", refresh_flag);
        end
        wait_edges(1);
        n_checks++;
        if (refresh_flag !== 1'b1) begin
            n_fail++;
            $display("FAIL midreq_flag_rise: got %0d expected 1 after edge 64", refresh_flag);
        end
    endtask

    task automatic test_stats();
        ref_gnt = 1'b1;
        do_reset();
        // rows complete at edges 90, 154, 218
        wait_edges(217);
        n_checks++;
        if (refresh_cnt !== (STATS ? 16'd2 : 16'd0)) begin
            n_fail++;
            $display("FAIL stats_two: got %0d expected %0d", refresh_cnt, STATS ? 2 : 0);
        end
        wait_edges(1);
        n_checks++;
        if ({refresh_cnt, ref_row_id} !== {(STATS ? 16'd3 : 16'd0), 7'd3}) begin
            n_fail++;
            $display("FAIL stats_three: got cnt=%0d row=%0d expected cnt=%0d row=3",
                     refresh_cnt, ref_row_id, STATS ? 3 : 0);
        end
    endtask

    task automatic test_wrap();
        int i;
        ref_gnt = 1'b1;
        do_reset();
        i = 0;
        do begin wait_edges(1); i++; end while (ref_row_id != 7'd127 && i < 9000);
        n_checks++;
        if (i != 8154) begin
            n_fail++;
            $display("FAIL wrap_reach127: row 127 after %0d edges expected 8154", i);
        end
        i = 0;
        do begin wait_edges(1); i++; end while (ref_row_id == 7'd127 && i < 200);
        n_checks++;
        if (i != 64 || ref_row_id !== 7'd0 || ref_bank_id !== 3'd0) begin
            n_fail++;
            $display("FAIL wrap_to0: after %0d edges row=%0d bank=%0d expected 64 edges row=0 bank=0",
                     i, ref_row_id, ref_bank_id);
        end
        n_checks++;
        if (refresh_cnt !== (STATS ? 16'd128 : 16'd0)) begin
            n_fail++;
            $display("FAIL wrap_cnt: got %0d expected %0d", refresh_cnt, STATS ? 128 : 0);
        end
    endtask

    initial begin
        rst_b   = 1'b0;
        ref_gnt = 1'b0;
        test_reset();
        test_first_row();
        test_saturate();
        test_coincide();
        test_reset_mid_req();
        test_stats();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
